banked_mem: RTL

Parametrised banked single-port memory: the successor to the fixed 16-bank × 256-word × 16-bit memory. Width, bank depth and bank count are generic. It adds a valid/ready request handshake and a read-valid strobe. The bank-select is registered so read data is muxed from the bank addressed in the request cycle. A post-reset zero-fill engine clears the whole array. It sits between the filter datapath/controller and the coefficient/sample storage, and replaces direct use of the flat memory.

---
 rtl/banked_mem_if.sv | 26 ++
 rtl/banked_mem.sv | 125 ++++++++++++
 2 files changed

// File: rtl/banked_mem_if.sv
// Request/response bundle for banked_mem: valid/ready request channel, read-valid strobe
// and zero-fill control.
interface banked_mem_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
);
    logic              init_start;
    logic              init_busy;
    logic              req_valid;
    logic              req_ready;
    logic              req_we_n;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output init_start, req_valid, req_we_n, req_addr, req_wdata,
        input  init_busy, req_ready, rd_valid, rd_data
    );

    modport slave (
        input  init_start, req_valid, req_we_n, req_addr, req_wdata,
        output init_busy, req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/banked_mem.sv
// Banked single-port memory with post-reset zero-fill and registered bank-select read mux.
// Define BANKED_MEM_OUT_REG_EN to add an output register stage (2-cycle read latency).
module banked_mem #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BANK_AW    = 8,
    parameter int unsigned BANK_SEL_W = 4
) (
    input logic           clk,
    input logic           rst,
    banked_mem_if.slave   bus
);
    localparam int unsigned ADDR_W   = BANK_SEL_W + BANK_AW;
    localparam int unsigned NumBanks = 1 << BANK_SEL_W;
    localparam int unsigned Depth    = 1 << BANK_AW;

    typedef enum logic {StInit, StRun} state_e;

    state_e                         state_q, state_d;
    logic [BANK_AW-1:0]             row_q, row_d;
    logic [BANK_SEL_W-1:0]          sel_q, sel_d;
    logic                           rd_valid_q, rd_valid_d;

    logic [NumBanks-1:0]            cen_n;
    logic                           wen_n;
    logic [BANK_AW-1:0]             bank_a;
    logic [DATA_W-1:0]              bank_d;
    logic [NumBanks-1:0][DATA_W-1:0] bank_q;

    logic                           accept;
    logic [BANK_SEL_W-1:0]          req_bank;

    assign req_bank = bus.req_addr[ADDR_W-1:BANK_AW];
    assign accept   = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        sel_d         = sel_q;
        rd_valid_d    = 1'b0;
        cen_n         = '1;
        wen_n         = 1'b1;
        bank_a        = bus.req_addr[BANK_AW-1:0];
        bank_d        = bus.req_wdata;
        bus.req_ready = 1'b0;
        bus.init_busy = 1'b0;
        unique case (state_q)
            StInit: begin
                bus.init_busy = 1'b1;
                cen_n         = '0;
                wen_n         = 1'b0;
                bank_a        = row_q;
                bank_d        = '0;
                row_d         = row_q + 1'b1;
                if (row_q == {BANK_AW{1'b1}}) begin
                    state_d = StRun;
                    row_d   = '0;
                end
            end
            StRun: begin
                bus.req_ready = 1'b1;
                if (accept) begin
                    cen_n = ~({{(NumBanks-1){1'b0}}, 1'b1} << req_bank);
                    wen_n = bus.req_we_n;
                    if (bus.req_we_n) begin
                        sel_d      = req_bank;
                        rd_valid_d = 1'b1;
                    end
                end
                // A request in the same cycle is still served; fill starts next edge.
                if (bus.init_start) state_d = StInit;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StInit;
            row_q      <= '0;
            sel_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            sel_q      <= sel_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Behavioural bank: synchronous single port, active-low CEN/WEN, 1-cycle read.
    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [DATA_W-1:0] mem_q [Depth];
        logic [DATA_W-1:0] q_q;

        always_ff @(posedge clk) begin
            if (!cen_n[b]) begin
                if (!wen_n) mem_q[bank_a] <= bank_d;
                else        q_q           <= mem_q[bank_a];
            end
        end

        assign bank_q[b] = q_q;
    end

`ifdef BANKED_MEM_OUT_REG_EN
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_o_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q    <= '0;
            rd_valid_o_q <= 1'b0;
        end else begin
            rd_valid_o_q <= rd_valid_q;
            if (rd_valid_q) rd_data_q <= bank_q[sel_q];
        end
    end

    assign bus.rd_valid = rd_valid_o_q;
    assign bus.rd_data  = rd_data_q;
`else
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = bank_q[sel_q];
`endif
endmodule
